// File: rtl/subtractor_pkg.sv
// Shared constants and FSM encoding for the bit-serial subtractor.
package subtractor_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : subtractor_pkg

// File: rtl/subtractor_serial_subbit.sv
// One-bit full-subtractor cell: diff = a - b - bin, bout set when a borrow is needed.
module subbit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  // Purely combinational difference and borrow-out
  always_comb begin
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule : subbit

// File: rtl/subtractor_serial.sv
// Bit-serial subtractor: one bit per clock, LSB first, through a single
// full-subtractor cell with the borrow carried in a flop between bits.
module subtractor_serial
  import subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam int              SH_W  = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             brw_q;
  logic [SH_W-1:0]  sh_q;
  logic [SH_W-1:0]  sh_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             borrow_q;
  logic             done_q;
  logic             cell_diff;
  logic             cell_bout;

  // The operand shift registers present their LSB to the single cell each cycle
  subbit u_bit (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (brw_q),
    .diff(cell_diff),
    .bout(cell_bout)
  );

  // Difference bits enter at the top so that after WIDTH-1 bits the
  // register holds bits 0..WIDTH-2 in place; the final bit joins at the MSB.
  always_comb begin
    sh_d = SH_W'({cell_diff, sh_q} >> 1);
  end

  // FSM plus datapath: accept in IDLE, shift one bit per edge in RUN,
  // publish result/borrow and pulse done on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      brw_q    <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= r1;
            b_q     <= r2;
            brw_q   <= bi;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          brw_q <= cell_bout;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_q  <= IDLE;
            result_q <= {cell_diff, sh_q};
            borrow_q <= cell_bout;
            done_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;
  assign borrow = borrow_q;

endmodule : subtractor_serial
